// File: rtl/control_cmd_encoder_if.sv
// Request and byte-stream signals between a command source/consumer and control_cmd_encoder.
// master = command source plus control-unit side, slave = the encoder.
interface control_cmd_encoder_if #(
  parameter int n_blocks             = 32,
  parameter int data_width           = 16,
  parameter int BLOCK_REG_ADDR_WIDTH = 4,
  parameter int BLOCK_INSTR_WIDTH    = 32
);
  localparam int BLOCK_W = (n_blocks > 1) ? $clog2(n_blocks) : 1;

  // Handshakes: a request transfers on the edge where cmd_valid & cmd_ready are both 1.
  // A byte transfers on the edge where next & out_ready are both 1; next is ignored otherwise.
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [7:0]                      cmd_opcode;
  logic [BLOCK_W-1:0]              cmd_block;
  logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg;
  logic [data_width-1:0]           cmd_data;
  logic [BLOCK_INSTR_WIDTH-1:0]    cmd_instr;
  logic [7:0]                      out_byte;
  logic                            out_ready;
  logic                            next;
  logic                            controller_ready;
  logic                            busy;
  logic                            done;
  logic                            invalid;

  modport master (
    output cmd_valid, cmd_opcode, cmd_block, cmd_reg, cmd_data, cmd_instr,
    output next, controller_ready,
    input  cmd_ready, out_byte, out_ready, busy, done, invalid
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_block, cmd_reg, cmd_data, cmd_instr,
    input  next, controller_ready,
    output cmd_ready, out_byte, out_ready, busy, done, invalid
  );
endinterface

// File: rtl/control_cmd_encoder.sv
// Serializes one control request into cmd/block/reg/data/instr bytes for the control unit.
// Optional feature macro: CMD_ENC_WAIT_IDLE_EN (gate acceptance on controller_ready).
module control_cmd_encoder #(
  parameter int n_blocks             = 32,
  parameter int data_width           = 16,
  parameter int BLOCK_REG_ADDR_WIDTH = 4,
  parameter int BLOCK_INSTR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  control_cmd_encoder_if.slave  bus,
  output logic [2:0]            state_dbg
);

  localparam int BLOCK_W     = (n_blocks > 1) ? $clog2(n_blocks) : 1;
  localparam int DATA_BYTES  = data_width / 8;
  localparam int INSTR_BYTES = BLOCK_INSTR_WIDTH / 8;
  localparam int PAY_W       = (data_width > BLOCK_INSTR_WIDTH) ? data_width : BLOCK_INSTR_WIDTH;

  // Command codes with the pipeline-select bit cleared.
  localparam logic [7:0] PIPE_SEL                  = 8'h08;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR = 8'h01;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG   = 8'h02;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG  = 8'h03;
  localparam logic [7:0] COMMAND_ALLOC_SRAM_DELAY  = 8'h04;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN    = 8'h05;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN   = 8'h06;
  localparam logic [7:0] COMMAND_SWAP_PIPELINES    = 8'h07;
  localparam logic [7:0] COMMAND_RESET_PIPELINE    = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_GAP    = 3'd2,
    S_BLOCK  = 3'd3,
    S_REG    = 3'd4,
    S_DATA   = 3'd5,
    S_INSTR  = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  state_t                          state;
  state_t                          ret_state;
  logic [7:0]                      out_byte_q;
  logic                            out_ready_q;
  logic                            done_q;
  logic                            invalid_q;
  logic [BLOCK_W-1:0]              blk_q;
  logic [BLOCK_REG_ADDR_WIDTH-1:0] reg_q;
  logic [PAY_W-1:0]                pay_sr;
  logic [7:0]                      pay_cnt;
  logic [7:0]                      byte_cnt;
  logic                            has_block;
  logic                            has_reg;
  logic                            pay_instr;

  logic   cmd_ready_c;
  logic   dec_known;
  logic   dec_block;
  logic   dec_reg;
  logic   dec_data;
  logic   dec_instr;
  state_t pay_state;
  state_t follow_state;
  logic   [7:0] follow_byte;
  logic   follow_is_pay;

`ifdef CMD_ENC_WAIT_IDLE_EN
  assign cmd_ready_c = (state == S_IDLE) && bus.controller_ready;
`else
  // FINISH always sits between the last byte and IDLE, which gives the receiver
  // its settling time back to READY before the next command byte.
  assign cmd_ready_c = (state == S_IDLE);
  logic ctrl_ready_unused;
  assign ctrl_ready_unused = bus.controller_ready;
`endif

  always_comb begin
    dec_known = 1'b1;
    dec_block = 1'b0;
    dec_reg   = 1'b0;
    dec_data  = 1'b0;
    dec_instr = 1'b0;
    case (bus.cmd_opcode & ~PIPE_SEL)
      COMMAND_WRITE_BLOCK_INSTR: begin
        dec_block = 1'b1;
        dec_instr = 1'b1;
      end
      COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG: begin
        dec_block = 1'b1;
        dec_reg   = 1'b1;
        dec_data  = 1'b1;
      end
      COMMAND_ALLOC_SRAM_DELAY, COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: begin
        dec_data = 1'b1;
      end
      COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE: begin
        dec_known = 1'b1;
      end
      default: dec_known = 1'b0;
    endcase
  end

  // Which byte follows the one currently presented, in frame order.
  assign pay_state = pay_instr ? S_INSTR : S_DATA;

  always_comb begin
    follow_state = S_FINISH;
    follow_byte  = pay_sr[PAY_W-1 -: 8];
    case (state)
      S_CMD: begin
        if (has_block) begin
          follow_state = S_BLOCK;
          follow_byte  = 8'(blk_q);
        end else if (pay_cnt != 8'd0) begin
          follow_state = pay_state;
        end
      end
      S_BLOCK: begin
        if (has_reg) begin
          follow_state = S_REG;
          follow_byte  = 8'(reg_q);
        end else if (pay_cnt != 8'd0) begin
          follow_state = pay_state;
        end
      end
      S_REG: begin
        if (pay_cnt != 8'd0) follow_state = pay_state;
      end
      S_DATA, S_INSTR: begin
        if (byte_cnt != pay_cnt - 8'd1) follow_state = state;
      end
      default: follow_state = S_FINISH;
    endcase
  end

  assign follow_is_pay = (follow_state == S_DATA) || (follow_state == S_INSTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ret_state   <= S_IDLE;
      out_byte_q  <= 8'd0;
      out_ready_q <= 1'b0;
      done_q      <= 1'b0;
      invalid_q   <= 1'b0;
      blk_q       <= '0;
      reg_q       <= '0;
      pay_sr      <= '0;
      pay_cnt     <= 8'd0;
      byte_cnt    <= 8'd0;
      has_block   <= 1'b0;
      has_reg     <= 1'b0;
      pay_instr   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_c) begin
            if (dec_known) begin
              state       <= S_CMD;
              out_byte_q  <= bus.cmd_opcode;
              out_ready_q <= 1'b1;
              blk_q       <= bus.cmd_block;
              reg_q       <= bus.cmd_reg;
              has_block   <= dec_block;
              has_reg     <= dec_reg;
              pay_instr   <= dec_instr;
              byte_cnt    <= 8'd0;
              // Payloads are left-aligned so the MSB byte always sits at the top.
              if (dec_instr) begin
                pay_sr  <= PAY_W'(bus.cmd_instr) << (PAY_W - BLOCK_INSTR_WIDTH);
                pay_cnt <= 8'(INSTR_BYTES);
              end else if (dec_data) begin
                pay_sr  <= PAY_W'(bus.cmd_data) << (PAY_W - data_width);
                pay_cnt <= 8'(DATA_BYTES);
              end else begin
                pay_sr  <= '0;
                pay_cnt <= 8'd0;
              end
            end else begin
              invalid_q <= 1'b1;
            end
          end
        end
        S_GAP: begin
          state       <= ret_state;
          out_ready_q <= 1'b1;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          if (bus.next && out_ready_q) begin
            out_ready_q <= 1'b0;
            if (follow_state == S_FINISH) begin
              state  <= S_FINISH;
              done_q <= 1'b1;
            end else begin
              state      <= S_GAP;
              ret_state  <= follow_state;
              out_byte_q <= follow_byte;
              if (follow_is_pay) begin
                pay_sr   <= pay_sr << 8;
                byte_cnt <= (state == follow_state) ? byte_cnt + 8'd1 : 8'd0;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_ready = out_ready_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.invalid   = invalid_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_control_cmd_encoder.sv
// Directed plus randomized bench for control_cmd_encoder with a frame-level reference model.
module tb_control_cmd_encoder;

  localparam int N_BLOCKS = 32;
  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int INSTR_W  = 32;

  localparam logic [7:0] C_WR_INSTR  = 8'h01;
  localparam logic [7:0] C_WR_REG    = 8'h02;
  localparam logic [7:0] C_UPD_REG   = 8'h03;
  localparam logic [7:0] C_ALLOC     = 8'h04;
  localparam logic [7:0] C_IN_GAIN   = 8'h05;
  localparam logic [7:0] C_OUT_GAIN  = 8'h06;
  localparam logic [7:0] C_SWAP      = 8'h07;
  localparam logic [7:0] C_RST_PIPE  = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] known_ops[8];

  control_cmd_encoder_if #(
    .n_blocks(N_BLOCKS), .data_width(DATA_W),
    .BLOCK_REG_ADDR_WIDTH(REG_W), .BLOCK_INSTR_WIDTH(INSTR_W)
  ) bus ();

  control_cmd_encoder #(
    .n_blocks(N_BLOCKS), .data_width(DATA_W),
    .BLOCK_REG_ADDR_WIDTH(REG_W), .BLOCK_INSTR_WIDTH(INSTR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the byte list a request must produce; returns 0 for unknown opcodes.
  function automatic bit model(input logic [7:0] op, input logic [4:0] blk, input logic [3:0] rg,
                               input logic [15:0] data, input logic [31:0] instr);
    logic [7:0] base;
    base = op & 8'hF7;
    exp_q.delete();
    case (base)
      C_WR_INSTR: begin
        exp_q.push_back(op);
        exp_q.push_back({3'b000, blk});
        for (int i = 3; i >= 0; i--) exp_q.push_back(instr[i*8 +: 8]);
      end
      C_WR_REG, C_UPD_REG: begin
        exp_q.push_back(op);
        exp_q.push_back({3'b000, blk});
        exp_q.push_back({4'b0000, rg});
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[7:0]);
      end
      C_ALLOC, C_IN_GAIN, C_OUT_GAIN: begin
        exp_q.push_back(op);
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[7:0]);
      end
      C_SWAP, C_RST_PIPE: exp_q.push_back(op);
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Driver: waits (bounded) for cmd_ready, presents one request, then scrambles the fields.
  task automatic send_request(input logic [7:0] op, input logic [4:0] blk, input logic [3:0] rg,
                              input logic [15:0] data, input logic [31:0] instr);
    int guard;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_block  = blk;
    bus.cmd_reg    = rg;
    bus.cmd_data   = data;
    bus.cmd_instr  = instr;
    tick();
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 8'($urandom);
    bus.cmd_block  = 5'($urandom);
    bus.cmd_reg    = 4'($urandom);
    bus.cmd_data   = 16'($urandom);
    bus.cmd_instr  = $urandom;
  endtask

  // Consumer + scoreboard: pulses next one cycle after each byte, optionally stalling on one byte.
  task automatic consume_frame(input string tag, input int stall_idx, input int stall_len);
    int n;
    int gaps;
    int dones;
    n = exp_q.size();
    gaps = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_out_ready"}, bus.out_ready, 1);
      check({tag, "_out_byte"}, bus.out_byte, exp_q[i]);
      check({tag, "_busy"}, bus.busy, 1);
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check({tag, "_stall_ready"}, bus.out_ready, 1);
          check({tag, "_stall_byte"}, bus.out_byte, exp_q[i]);
        end
      end
      tick();
      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      if (bus.out_ready === 1'b0) gaps++;
      if (bus.done === 1'b1) dones++;
      if (i < n - 1) begin
        check({tag, "_gap_byte"}, bus.out_byte, exp_q[i+1]);
        tick();
      end
    end
    check({tag, "_gap_cycles"}, gaps, n);
    check({tag, "_done_count"}, dones, 1);
    tick();
    check({tag, "_done_clear"}, bus.done, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_idle_out_ready"}, bus.out_ready, 0);
    check({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  task automatic invalid_request(input logic [7:0] op);
    send_request(op, 5'($urandom), 4'($urandom), 16'($urandom), $urandom);
    check("inv_pulse", bus.invalid, 1);
    check("inv_out_ready", bus.out_ready, 0);
    check("inv_cmd_ready", bus.cmd_ready, 1);
    check("inv_busy", bus.busy, 0);
    tick();
    check("inv_pulse_clear", bus.invalid, 0);
    check("inv_out_ready2", bus.out_ready, 0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [4:0]  blk;
    logic [3:0]  rg;
    logic [15:0] data;
    logic [31:0] instr;
    int          sidx;
    int          slen;

    known_ops = '{C_WR_INSTR, C_WR_REG, C_UPD_REG, C_ALLOC, C_IN_GAIN, C_OUT_GAIN, C_SWAP, C_RST_PIPE};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 8'h00;
    bus.cmd_block = '0;
    bus.cmd_reg = '0;
    bus.cmd_data = '0;
    bus.cmd_instr = '0;
    bus.next = 1'b0;
    bus.controller_ready = 1'b1;
    tick();
    tick();
    check("rst_out_byte", bus.out_byte, 0);
    check("rst_out_ready", bus.out_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_invalid", bus.invalid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    bus.controller_ready = 1'b0;
    #1;
`ifdef CMD_ENC_WAIT_IDLE_EN
    check("ctrl_ready_gates", bus.cmd_ready, 0);
`else
    check("ctrl_ready_ignored", bus.cmd_ready, 1);
`endif
    bus.controller_ready = 1'b1;
    tick();

    // Register write
    void'(model(C_WR_REG, 5'd5, 4'd3, 16'hBEEF, 32'h0));
    send_request(C_WR_REG, 5'd5, 4'd3, 16'hBEEF, 32'h0);
    consume_frame("reg_write", -1, 0);

    // Instruction write
    void'(model(C_WR_INSTR, 5'd31, 4'd0, 16'h0, 32'h12345678));
    send_request(C_WR_INSTR, 5'd31, 4'd0, 16'h0, 32'h12345678);
    consume_frame("instr_write", -1, 0);

    // Single-byte command and unknown opcode
    void'(model(C_SWAP, 5'd0, 4'd0, 16'h0, 32'h0));
    send_request(C_SWAP, 5'd0, 4'd0, 16'h0, 32'h0);
    consume_frame("swap", -1, 0);
    invalid_request(8'hFF);

    // Stalled consumer on the data MSB
    void'(model(C_WR_REG, 5'd5, 4'd3, 16'hBEEF, 32'h0));
    send_request(C_WR_REG, 5'd5, 4'd3, 16'hBEEF, 32'h0);
    consume_frame("stall", 3, 20);

    // Reset while the reg byte is presented
    void'(model(C_WR_REG, 5'd7, 4'd9, 16'h1234, 32'h0));
    send_request(C_WR_REG, 5'd7, 4'd9, 16'h1234, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      tick();
    end
    check("pre_rst_reg_byte", bus.out_byte, exp_q[2]);
    check("pre_rst_out_ready", bus.out_ready, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_out_ready", bus.out_ready, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_byte", bus.out_byte, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    void'(model(C_UPD_REG ^ 8'h08, 5'd12, 4'd6, 16'hC0DE, 32'h0));
    send_request(C_UPD_REG ^ 8'h08, 5'd12, 4'd6, 16'hC0DE, 32'h0);
    consume_frame("post_rst", -1, 0);

`ifdef CMD_ENC_WAIT_IDLE_EN
    // Controller still busy after done: no acceptance until controller_ready rises
    void'(model(C_IN_GAIN, 5'd0, 4'd0, 16'hA55A, 32'h0));
    send_request(C_IN_GAIN, 5'd0, 4'd0, 16'hA55A, 32'h0);
    consume_frame("pre_wait", -1, 0);
    bus.controller_ready = 1'b0;
    void'(model(C_SWAP ^ 8'h08, 5'd0, 4'd0, 16'h0, 32'h0));
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = C_SWAP ^ 8'h08;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait_cmd_ready", bus.cmd_ready, 0);
      check("wait_out_ready", bus.out_ready, 0);
    end
    bus.controller_ready = 1'b1;
    #1;
    check("wait_release", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    consume_frame("after_wait", -1, 0);
`endif

    // Randomized requests against the model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 7)
        op = known_ops[$urandom_range(0, 7)] ^ (($urandom_range(0, 1) == 1) ? 8'h08 : 8'h00);
      else
        op = 8'($urandom_range(0, 255));
      blk   = 5'($urandom);
      rg    = 4'($urandom);
      data  = 16'($urandom);
      instr = $urandom;
      if (model(op, blk, rg, data, instr)) begin
        sidx = $urandom_range(0, exp_q.size() - 1);
        slen = $urandom_range(0, 3);
        send_request(op, blk, rg, data, instr);
        consume_frame("rand", sidx, slen);
      end else begin
        invalid_request(op);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
